// File: rtl/sram_master.sv
// Request-stream front end for a single-port SRAM: one access per request, byte-lane writes,
// and a hardware sweep that fills [MEMBASE:MEMTOP] with INIT_VALUE.
module sram_master #(
    parameter int unsigned          DATAWIDTH  = 32,
    parameter int unsigned          ADDRWIDTH  = 16,
    parameter logic [ADDRWIDTH-1:0] MEMBASE    = 16'h0000,
    parameter logic [ADDRWIDTH-1:0] MEMTOP     = 16'hFFFF,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [3:0]           req_be,
    input  logic [DATAWIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    input  logic                 init_start,
    output logic                 init_busy,
    output logic                 init_done,
    output logic [ADDRWIDTH-1:0] ADDRESS,
    output logic                 CS,
    output logic [3:0]           WE,
    output logic [DATAWIDTH-1:0] WDATA,
    input  logic [DATAWIDTH-1:0] RDATA
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp, StInit} state_e;

    state_e                 r_state, w_state_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic [DATAWIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic                   r_rsp_err, w_rsp_err_nxt;
    logic                   r_init_busy, w_init_busy_nxt;
    logic                   r_init_done, w_init_done_nxt;
    logic [ADDRWIDTH-1:0]   r_addr, w_addr_nxt;
    logic                   r_cs, w_cs_nxt;
    logic [3:0]             r_we, w_we_nxt;
    logic [DATAWIDTH-1:0]   r_wdata, w_wdata_nxt;
    // One bit wider than the address so a sweep ending at all-ones cannot wrap.
    logic [ADDRWIDTH:0]     r_init_cnt, w_init_cnt_nxt;

    logic                   w_below;
    logic                   w_above;
    logic                   w_illegal;
    logic                   w_sweep_last;
    logic [ADDRWIDTH:0]     w_cnt_inc;

    // Range bounds at the extremes of the address space are elided to keep compares non-constant.
    if (MEMBASE == '0) begin : g_no_floor
        assign w_below = 1'b0;
    end else begin : g_floor
        assign w_below = (req_addr < MEMBASE);
    end

    if (MEMTOP == '1) begin : g_no_ceiling
        assign w_above = 1'b0;
    end else begin : g_ceiling
        assign w_above = (req_addr > MEMTOP);
    end

    assign w_illegal    = w_below | w_above | (req_write & ~|req_be);
    assign w_sweep_last = (r_init_cnt == {1'b0, MEMTOP});
    assign w_cnt_inc    = r_init_cnt + {{ADDRWIDTH{1'b0}}, 1'b1};

    assign req_ready = RSTn & (r_state == StIdle) & ~init_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign init_busy = r_init_busy;
    assign init_done = r_init_done;
    assign ADDRESS   = r_addr;
    assign CS        = r_cs;
    assign WE        = r_we;
    assign WDATA     = r_wdata;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_init_busy <= 1'b0;
            r_init_done <= 1'b0;
            r_addr      <= '0;
            r_cs        <= 1'b0;
            r_we        <= 4'h0;
            r_wdata     <= '0;
            r_init_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_init_busy <= w_init_busy_nxt;
            r_init_done <= w_init_done_nxt;
            r_addr      <= w_addr_nxt;
            r_cs        <= w_cs_nxt;
            r_we        <= w_we_nxt;
            r_wdata     <= w_wdata_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_init_busy_nxt = 1'b0;
        w_init_done_nxt = 1'b0;
        w_addr_nxt      = r_addr;
        w_cs_nxt        = 1'b0;
        w_we_nxt        = 4'h0;
        w_wdata_nxt     = r_wdata;
        w_init_cnt_nxt  = r_init_cnt;

        unique case (r_state)
            StIdle: begin
                if (init_start) begin
                    w_state_nxt     = StInit;
                    w_init_busy_nxt = 1'b1;
                    w_init_cnt_nxt  = {1'b0, MEMBASE};
                    w_addr_nxt      = MEMBASE;
                    w_cs_nxt        = 1'b1;
                    w_we_nxt        = 4'hF;
                    w_wdata_nxt     = INIT_VALUE;
                end else if (req_valid) begin
                    if (w_illegal) begin
                        w_state_nxt     = StResp;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_data_nxt  = '0;
                    end else begin
                        w_state_nxt = StAccess;
                        w_addr_nxt  = req_addr;
                        w_cs_nxt    = 1'b1;
                        if (req_write) begin
                            w_we_nxt    = req_be;
                            w_wdata_nxt = req_wdata;
                        end
                    end
                end
            end
            StAccess: begin
                // WE still holds the access type: all-zero means this was a read.
                w_state_nxt     = StResp;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b0;
                w_rsp_data_nxt  = (r_we == 4'h0) ? RDATA : '0;
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_nxt     = StIdle;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            StInit: begin
                if (w_sweep_last) begin
                    w_state_nxt     = StIdle;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_init_busy_nxt = 1'b1;
                    w_init_cnt_nxt  = w_cnt_inc;
                    w_addr_nxt      = w_cnt_inc[ADDRWIDTH-1:0];
                    w_cs_nxt        = 1'b1;
                    w_we_nxt        = 4'hF;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule
